// File: rtl/tt_um_uart_char_tx.sv
// UART 8N1 transmitter for the character sequencer. A small FIFO holds ASCII
// codes, and a two-process FSM sends them back to back on tx_out.
module tt_um_uart_char_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_overflow,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;

  logic            push_s;
  logic            drop_s;
  logic            pop_s;
  logic            empty_s;
  logic            baud_last_s;
  logic [7:0]      head_s;

  assign empty_s     = (count_q == {CW{1'b0}});
  assign baud_last_s = (baud_q == BAUD_LAST);
  assign head_s      = mem_q[rd_ptr_q];
  // Acceptance looks only at the registered full flag; a same-cycle pop never frees a slot.
  assign push_s      = in_valid & ~full_q;
  assign drop_s      = in_valid & full_q;

  assign in_ready   = ~full_q;
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = {BW{1'b0}};
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          baud_d    = {BW{1'b0}};
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        // The shift register moves right so the next bit to send is always at [1].
        if (baud_last_s) begin
          baud_d = {BW{1'b0}};
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_d = {BW{1'b0}};
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = {BW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == COUNT_FULL);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= {BW{1'b0}};
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_tt_um_uart_char_tx.sv
// Bench for tt_um_uart_char_tx: a timing model schedules each accepted byte's
// frame start; a line receiver decodes tx_out and checks frames against a queue.
module tb_tt_um_uart_char_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       in_ready;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  tt_um_uart_char_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr_overflow(clr_overflow), .tx_out(tx_out),
    .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_edges = 0;

  // Model: each queued byte's pop edge, plus the byte itself for the receiver.
  int         pend_q[$];
  logic [7:0] exp_q[$];
  int         last_sched = -1000;
  int         last_popped = -1000;
  bit         m_ovf = 1'b0;

  always @(posedge clk) done_edges <= done_edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void prune();
    while (pend_q.size() > 0 && pend_q[0] <= done_edges)
      last_popped = pend_q.pop_front();
  endfunction

  function automatic bit model_busy();
    prune();
    return (done_edges >= last_popped) && (done_edges <= last_popped + FRAME - 1);
  endfunction

  task automatic check_outputs();
    bit mb;
    mb = model_busy();
    chk("fifo_count", int'(fifo_count), pend_q.size());
    chk("in_ready", int'(in_ready), int'(pend_q.size() < DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("busy", int'(busy), int'(mb));
    if (!mb) chk("tx_idle_high", int'(tx_out), 1);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    int p;
    @(negedge clk);
    check_outputs();
    in_valid     = v;
    in_data      = d;
    clr_overflow = clr;
    if (v && pend_q.size() < DEPTH) begin
      p = done_edges + 2;
      if (last_sched + FRAME > p) p = last_sched + FRAME;
      pend_q.push_back(p);
      exp_q.push_back(d);
      last_sched = p;
    end
    if (v && pend_q.size() >= DEPTH && !(pend_q.size() > 0 && pend_q[pend_q.size()-1] == last_sched && last_sched == p && v))
      m_ovf = 1'b1;
    else if (clr)
      m_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || model_busy()) && k < 2000) begin
      step(1'b0, 8'($urandom), 1'b0);
      k++;
    end
    chk("drain_exp_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset_async();
    @(negedge clk);
    #2;
    reset = 1'b1;
    pend_q.delete();
    exp_q.delete();
    last_sched  = -1000;
    last_popped = -1000;
    m_ovf       = 1'b0;
    #1;
    chk("rst_tx_out", int'(tx_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  // Line receiver: 40 samples per frame, one per falling clock edge.
  bit               in_frame = 1'b0;
  int               sidx = 0;
  logic [FRAME-1:0] smp;
  logic [7:0]       rx_byte;
  int               bad;
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_out == 1'b0) begin
        in_frame = 1'b1;
        smp[0]   = 1'b0;
        sidx     = 1;
      end
    end else begin
      smp[sidx] = tx_out;
      sidx++;
      if (sidx == FRAME) begin
        in_frame = 1'b0;
        bad = 0;
        for (int b = 0; b < 10; b++)
          for (int s = 1; s < CPB; s++)
            if (smp[b*CPB+s] !== smp[b*CPB]) bad++;
        chk("bit_width_stable", bad, 0);
        chk("stop_bit", int'(smp[9*CPB]), 1);
        for (int k = 0; k < 8; k++) rx_byte[k] = smp[(k+1)*CPB];
        chk("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("frame_data", int'(rx_byte), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int first_p;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    idle(100);

    step(1'b1, 8'h47, 1'b0);
    drain();

    step(1'b1, 8'h51, 1'b0);
    step(1'b1, 8'h51, 1'b0);
    drain();

    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5B, 1'b1);
    idle(2);
    drain();
    step(1'b0, 8'h00, 1'b1);
    idle(1);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 35), 8'($urandom), ($urandom_range(0, 99) < 5));
    drain();

    step(1'b1, 8'h31, 1'b0);
    first_p = last_sched;
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 100 && done_edges < first_p + 13; i++) idle(1);
    chk("mid_frame_queued", pend_q.size(), 2);
    do_reset_async();
    idle(100);
    chk("no_frames_after_reset", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
